seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a bank of DIGITS common-anode 7-segment displays. One segment bus is shared by all digits, with one enable line per digit.
- Latches a packed hex word on a load strobe, then scans the digits round-robin at a programmable rate.
- Each selected digit's nibble is decoded to active-low segments, with per-digit decimal point, enable mask and anti-ghosting blank time.
- Sits between user logic (counters, ALU results, keyboard codes) and the board's seg/anode pins.

---
 rtl/seg7_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-digit dp, enable mask and blank time.
// Optional leading-zero suppression is compiled in when SEG7_LZS_EN is defined.
module seg7_scan_driver #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 1024,
    parameter int unsigned BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_OFF = 7'h7F;

    if (DIGITS < 2) begin : g_bad_digits
        $error("seg7_scan_driver: DIGITS must be at least 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("seg7_scan_driver: DIV must be at least 2");
    end
    if (BLANK >= DIV) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK must be less than DIV");
    end

    // Active-low {g,f,e,d,c,b,a} hex font
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   data_sh;
    logic [DIGITS-1:0]     dp_sh;
    logic [DIGITS-1:0]     en_sh;
    logic                  slot_en;

    logic                  tick;
    logic [CW-1:0]         cnt_next;
    logic [IW-1:0]         idx_next;
    logic                  slot_en_next;
    logic                  blank_ok;
    logic                  blank_digit;
    logic [3:0]            nib_next;
    logic [6:0]            seg_next;
    logic                  dp_n_next;
    logic [DIGITS-1:0]     an_next;
    logic                  frame_next;

`ifdef SEG7_LZS_EN
    logic [DIGITS-1:0]     lz;
    logic                  zero_run;

    // A digit is suppressed while every nibble from the top down to it is zero; digit 0 never is
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (data_sh[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
    end
`endif

    // Anodes stay off for the first BLANK cycles of every slot
    if (BLANK == 0) begin : g_no_blank
        assign blank_ok = 1'b1;
    end else begin : g_blank
        assign blank_ok = (cnt_next >= CW'(BLANK));
    end

    // Prescaler, scan index and next-slot decode from the current shadow
    always_comb begin
        tick         = (cnt == CNT_MAX);
        cnt_next     = cnt + CW'(1);
        idx_next     = idx;
        slot_en_next = slot_en;
        frame_next   = 1'b0;
        if (tick) begin
            cnt_next     = '0;
            idx_next     = (idx == IDX_MAX) ? '0 : idx + IW'(1);
            slot_en_next = en_sh[idx_next];
            frame_next   = (idx == IDX_MAX);
        end

        nib_next = data_sh[4*idx_next +: 4];
`ifdef SEG7_LZS_EN
        blank_digit = lz[idx_next];
`else
        blank_digit = 1'b0;
`endif
        seg_next  = SEG_OFF;
        dp_n_next = 1'b1;
        if (en_sh[idx_next]) begin
            seg_next  = blank_digit ? SEG_OFF : hex7(nib_next);
            dp_n_next = ~dp_sh[idx_next];
        end

        an_next = '1;
        if (slot_en_next && blank_ok) begin
            an_next = ~(DIGITS'(1) << idx_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            slot_en <= 1'b0;
            data_sh <= '0;
            dp_sh   <= '0;
            en_sh   <= '0;
            seg     <= SEG_OFF;
            dp_n    <= 1'b1;
            an      <= '1;
            frame   <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            idx     <= idx_next;
            slot_en <= slot_en_next;
            an      <= an_next;
            frame   <= frame_next;
            // Segments change only at slot boundaries so they settle before the anode lights
            if (tick) begin
                seg  <= seg_next;
                dp_n <= dp_n_next;
            end
            if (load) begin
                data_sh <= data;
                dp_sh   <= dp;
                en_sh   <= en;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a slot-level model predicts every output cycle.
// Leading-zero expectations follow SEG7_LZS_EN when it is defined for the build.
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned BLANK  = 1;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (data),
        .dp    (dp),
        .en    (en),
        .seg   (seg),
        .dp_n  (dp_n),
        .an    (an),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [6:0]  font [16];
    logic [15:0] m_data, s_data;
    logic [3:0]  m_dp, m_en, s_dp, s_en;
    int          k;
    logic [12:0] exp_q [$];

    localparam logic [12:0] DARK = {7'h7F, 1'b1, 4'hF, 1'b0};

    function automatic logic [12:0] outs();
        return {seg, dp_n, an, frame};
    endfunction

    // Expected {seg,dp_n,an,frame} for the cycle after edge kk, from the slot snapshot
    function automatic logic [12:0] predict(input int kk);
        int         m, ph, d;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        logic       e_fr;
        logic [3:0] nib;
        logic       blank;
        m     = kk / DIV;
        ph    = kk % DIV;
        d     = m % DIGITS;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_an  = 4'hF;
        e_fr  = (kk > 0) && (ph == 0) && (d == 0);
        if (s_en[d]) begin
            nib   = s_data[4*d +: 4];
            blank = 1'b0;
`ifdef SEG7_LZS_EN
            if (d > 0) begin
                blank = 1'b1;
                for (int j = d; j < DIGITS; j++)
                    if (s_data[4*j +: 4] != 4'h0) blank = 1'b0;
            end
`endif
            e_seg = blank ? 7'h7F : font[nib];
            e_dp  = ~s_dp[d];
            if (ph >= BLANK) e_an = ~(4'b0001 << d);
        end
        return {e_seg, e_dp, e_an, e_fr};
    endfunction

    task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        logic [12:0] exp;
        load = ld;
        data = d;
        dp   = p;
        en   = e;
        @(posedge clk);
        k++;
        if (k % DIV == 0) begin
            s_data = m_data;
            s_dp   = m_dp;
            s_en   = m_en;
        end
        if (ld) begin
            m_data = d;
            m_dp   = p;
            m_en   = e;
        end
        exp_q.push_back(predict(k));
        @(negedge clk);
        load = 1'b0;
        check_eq("queue_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_eq($sformatf("outs_k%0d", k), 32'(outs()), 32'(exp));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // Reset asserted between edges must darken the display at once and hold it dark
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", 32'(outs()), 32'(DARK));
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_hold", 32'(outs()), 32'(DARK));
        end
        rst_n  = 1'b1;
        k      = 0;
        m_data = '0; m_dp = '0; m_en = '0;
        s_data = '0; s_dp = '0; s_en = '0;
        exp_q.delete();
        check_eq("rst_release", 32'(outs()), 32'(DARK));
    endtask

    initial begin
        font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
        font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
        font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
        font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;
        rst_n = 1'b0;
        load  = 1'b0;
        data  = '0;
        dp    = '0;
        en    = '0;
        k     = 0;

        do_reset();
        cycle(1'b1, 16'h1A3F, 4'b0000, 4'hF);
        idle(40);
        cycle(1'b1, 16'h1A3F, 4'b0000, 4'b1011);
        idle(20);
        cycle(1'b1, 16'h1A3F, 4'b0100, 4'hF);
        idle(20);
        // Load landing exactly on a slot boundary
        while ((k + 1) % DIV != 0) idle(1);
        cycle(1'b1, 16'h2222, 4'b0000, 4'hF);
        idle(20);
        cycle(1'b1, 16'hABCD, 4'hF, 4'hF);
        cycle(1'b1, 16'h9876, 4'h0, 4'hF);
        idle(20);
        cycle(1'b1, 16'h0050, 4'b0000, 4'hF);
        idle(20);
        cycle(1'b1, 16'h0000, 4'b0000, 4'hF);
        idle(20);
        cycle(1'b1, 16'h0000, 4'b1000, 4'hF);
        idle(20);
        repeat (6) begin
            cycle(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            idle(int'($urandom_range(1, 9)));
        end
        idle(3);
        do_reset();
        cycle(1'b1, 16'hC0DE, 4'b0001, 4'hF);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
